// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone SDRAM port arbiter.
package wb_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // One-hot grant vector for a given owner index
   function automatic logic [1:0] grant_vec(input logic owner);
      return (owner == M1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin winner selection between two requesters. The master that was
// served last loses a tie, so two saturating masters alternate.
module wb_arb_rr_pick
   import wb_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_valid,
   output logic       o_winner
);

   // Tie goes to the master that was not served last; otherwise the sole requester wins
   always_comb begin
      o_valid  = |i_req;
      o_winner = M0;
      if (i_req == 2'b11) begin
         o_winner = ~i_last;
      end else if (i_req[1]) begin
         o_winner = M1;
      end
   end

endmodule

// File: rtl/wb_sdram_port_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller.
// A grant is held for the full Wishbone cycle (cyc high) so bursts are never
// split, and one idle cycle always separates consecutive grants.
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN to abort a cycle whose
// slave has not acked within TIMEOUT_CYC strobed cycles.
//
// Handshake: the owner's cyc/stb pass straight through to the slave while the
// arbiter is in OWN; the slave's ack/err are routed back to the owner only,
// and the non-owner sees ack=err=0 until it is granted.
module wb_sdram_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic            wb_clk,
   input  logic            wb_rst_n,

   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,

   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,

   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,

   output logic [1:0]      grant_o
);

   arb_state_e      r_state;
   logic            r_owner;
   logic            r_last;
   logic [1:0]      r_grant;

   logic            w_active;
   logic            w_pick_valid;
   logic            w_pick_winner;
   logic            w_timeout;
   logic            w_release;

   logic [AW-1:0]   w_own_adr;
   logic [DW-1:0]   w_own_dat;
   logic [DW/8-1:0] w_own_sel;
   logic            w_own_we;
   logic            w_own_cyc;
   logic            w_own_stb;

   wb_arb_rr_pick u_pick (
      .i_req    ({m1_cyc_i, m0_cyc_i}),
      .i_last   (r_last),
      .o_valid  (w_pick_valid),
      .o_winner (w_pick_winner)
   );

   assign w_active  = (r_state == ARB_OWN);
   assign w_release = w_active && (!w_own_cyc || w_timeout);

   // Select the current owner's request signals
   always_comb begin
      w_own_adr = m0_adr_i;
      w_own_dat = m0_dat_i;
      w_own_sel = m0_sel_i;
      w_own_we  = m0_we_i;
      w_own_cyc = m0_cyc_i;
      w_own_stb = m0_stb_i;
      if (r_owner == M1) begin
         w_own_adr = m1_adr_i;
         w_own_dat = m1_dat_i;
         w_own_sel = m1_sel_i;
         w_own_we  = m1_we_i;
         w_own_cyc = m1_cyc_i;
         w_own_stb = m1_stb_i;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_tcnt;

   assign w_timeout = w_active && (r_tcnt == TW'(TIMEOUT_CYC));

   // Count strobed cycles the slave leaves unanswered; any ack/err or release restarts it
   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         r_tcnt <= '0;
      end else if (w_release || s_ack_i || s_err_i) begin
         r_tcnt <= '0;
      end else if (w_active && s_stb_o) begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end
`else
   logic w_unused_timeout_cfg;
   assign w_timeout            = 1'b0;
   assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

   // Arbitration FSM: grant on request, hold for the whole cycle, release through IDLE
   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         r_state <= ARB_IDLE;
         r_owner <= M0;
         r_last  <= M1;
         r_grant <= 2'b00;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_valid) begin
                  r_state <= ARB_OWN;
                  r_owner <= w_pick_winner;
                  r_grant <= grant_vec(w_pick_winner);
               end
            end
            ARB_OWN: begin
               if (w_release) begin
                  r_state <= ARB_IDLE;
                  r_last  <= r_owner;
                  r_grant <= 2'b00;
               end
            end
         endcase
      end
   end

   assign grant_o = r_grant;

   // Slave side is quiet unless a master owns the port; a timeout drops cyc/stb for its abort cycle
   assign s_adr_o = w_active ? w_own_adr : '0;
   assign s_dat_o = w_active ? w_own_dat : '0;
   assign s_sel_o = w_active ? w_own_sel : '0;
   assign s_we_o  = w_active && w_own_we;
   assign s_cyc_o = w_active && w_own_cyc && !w_timeout;
   assign s_stb_o = w_active && w_own_stb && !w_timeout;

   // Read data is broadcast; ack/err reach only the owner
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = w_active && (r_owner == M0) && s_ack_i;
   assign m1_ack_o = w_active && (r_owner == M1) && s_ack_i;
   assign m0_err_o = w_active && (r_owner == M0) && (s_err_i || w_timeout);
   assign m1_err_o = w_active && (r_owner == M1) && (s_err_i || w_timeout);

endmodule
